// File: rtl/ascon_pkg.sv
// Register map, mode/status encodings and sequencer state type shared by the
// ascon job sequencer and anything that talks to the ascon_wrapper slave.
package ascon_pkg;

   localparam logic [4:0] REG_CTRL   = 5'd0;
   localparam logic [4:0] REG_KEY0   = 5'd1;
   localparam logic [4:0] REG_NONCE0 = 5'd5;
   localparam logic [4:0] REG_AD0    = 5'd9;
   localparam logic [4:0] REG_DIN0   = 5'd13;
   localparam logic [4:0] REG_STATUS = 5'd17;
   localparam logic [4:0] REG_DOUT0  = 5'd18;
   localparam logic [4:0] REG_TAG0   = 5'd22;

   localparam int STATUS_DONE = 0;
   localparam int STATUS_AUTH = 1;

   typedef enum logic [1:0] {
      MODE_ENC = 2'd0,
      MODE_DEC = 2'd1
   } ascon_mode_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_CFG,
      WR_START,
      WR_CLR,
      POLL_RD,
      POLL_WAIT,
      RD_OUT,
      RESP
   } seq_state_t;

   function automatic logic [31:0] ctrl_word(input logic [1:0] mode, input logic start);
      return {29'b0, mode, start};
   endfunction

endpackage

// File: rtl/ascon_job_sequencer.sv
// Avalon-MM master that runs one AEAD job at a time on ascon_wrapper: programs
// the config registers, starts the core, polls status and reads the result back.
module ascon_job_sequencer
   import ascon_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int POLL_GAP     = 4,
   parameter int POLL_MAX     = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [1:0]   job_mode,
   input  logic [127:0] job_key,
   input  logic [127:0] job_nonce,
   input  logic [127:0] job_ad,
   input  logic [127:0] job_din,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_dout,
   output logic [127:0] res_tag,
   output logic         res_auth_ok,
   output logic         res_err,
   output logic         av_chipselect,
   output logic         av_write,
   output logic         av_read,
   output logic [4:0]   av_address,
   output logic [31:0]  av_writedata,
   input  logic [31:0]  av_readdata
);

   localparam int               POLL_W    = $clog2(POLL_MAX + 1);
   localparam logic [7:0]       CAP_CNT   = 8'(READ_LATENCY + 1);
   localparam logic [7:0]       GAP_END   = 8'(READ_LATENCY + POLL_GAP);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

   seq_state_t        state, state_n;
   logic [3:0]        idx, idx_n;
   logic [7:0]        cnt, cnt_n, cnt_inc;
   logic [POLL_W-1:0] poll_cnt, poll_n;

   logic [1:0]   mode_r;
   logic [127:0] key_r, nonce_r, ad_r, din_r;
   logic [127:0] field;
   logic [31:0]  cfg_word;

   logic        wr_n, rd_n;
   logic [4:0]  addr_n;
   logic [31:0] wdata_n;
   logic        accept, cap_status, cap_word, set_err, set_valid;

   assign job_ready     = (state == IDLE);
   assign av_chipselect = av_write | av_read;
   assign cnt_inc       = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // Config word for write index idx: key, nonce, AD, din in turn, MSW first.
   always_comb begin
      field = key_r;
      unique case (idx[3:2])
         2'd0:    field = key_r;
         2'd1:    field = nonce_r;
         2'd2:    field = ad_r;
         default: field = din_r;
      endcase
      unique case (idx[1:0])
         2'd0:    cfg_word = field[127:96];
         2'd1:    cfg_word = field[95:64];
         2'd2:    cfg_word = field[63:32];
         default: cfg_word = field[31:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         cnt      <= '0;
         poll_cnt <= '0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         cnt      <= cnt_n;
         poll_cnt <= poll_n;
      end
   end

   // Bus strobes are registered, so each state's bus cycle appears one clock later;
   // cnt==1 marks the cycle the read strobe is on the bus, CAP_CNT the data cycle.
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      cnt_n      = cnt;
      poll_n     = poll_cnt;
      wr_n       = 1'b0;
      rd_n       = 1'b0;
      addr_n     = av_address;
      wdata_n    = av_writedata;
      accept     = 1'b0;
      cap_status = 1'b0;
      cap_word   = 1'b0;
      set_err    = 1'b0;
      set_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            if (job_valid) begin
               accept = 1'b1;
               if (job_mode[1]) begin
                  state_n = RESP;
                  set_err = 1'b1;
               end else begin
                  state_n = WR_CFG;
                  idx_n   = '0;
               end
            end
         end
         WR_CFG: begin
            wr_n    = 1'b1;
            addr_n  = REG_KEY0 + {1'b0, idx};
            wdata_n = cfg_word;
            if (idx == 4'd15) state_n = WR_START;
            else              idx_n   = idx + 4'd1;
         end
         WR_START: begin
            wr_n    = 1'b1;
            addr_n  = REG_CTRL;
            wdata_n = ctrl_word(mode_r, 1'b1);
            state_n = WR_CLR;
         end
         WR_CLR: begin
            wr_n    = 1'b1;
            addr_n  = REG_CTRL;
            wdata_n = ctrl_word(mode_r, 1'b0);
            poll_n  = '0;
            state_n = POLL_RD;
         end
         POLL_RD: begin
            rd_n    = 1'b1;
            addr_n  = REG_STATUS;
            cnt_n   = 8'd1;
            state_n = POLL_WAIT;
         end
         POLL_WAIT: begin
            cnt_n = cnt_inc;
            if (cnt == CAP_CNT) begin
               cap_status = 1'b1;
               if (av_readdata[STATUS_DONE]) begin
                  state_n = RD_OUT;
                  idx_n   = '0;
                  cnt_n   = 8'd0;
               end else if (poll_cnt >= POLL_LAST) begin
                  state_n   = RESP;
                  set_err   = 1'b1;
                  set_valid = 1'b1;
               end else begin
                  poll_n = poll_cnt + POLL_W'(1);
               end
            end
            if (state_n == POLL_WAIT && cnt >= CAP_CNT && cnt >= GAP_END)
               state_n = POLL_RD;
         end
         RD_OUT: begin
            if (cnt == 8'd0) begin
               rd_n   = 1'b1;
               addr_n = REG_DOUT0 + {1'b0, idx};
               cnt_n  = 8'd1;
            end else if (cnt == CAP_CNT) begin
               cap_word = 1'b1;
               if (idx == 4'd7) begin
                  state_n   = RESP;
                  set_valid = 1'b1;
               end else begin
                  idx_n  = idx + 4'd1;
                  rd_n   = 1'b1;
                  addr_n = REG_DOUT0 + 5'd1 + {1'b0, idx};
                  cnt_n  = 8'd1;
               end
            end else begin
               cnt_n = cnt_inc;
            end
         end
         RESP: begin
            if (!res_valid)     set_valid = 1'b1;
            else if (res_ready) state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Result fields are cleared on acceptance so error results read back as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         av_write     <= 1'b0;
         av_read      <= 1'b0;
         av_address   <= '0;
         av_writedata <= '0;
         mode_r       <= '0;
         key_r        <= '0;
         nonce_r      <= '0;
         ad_r         <= '0;
         din_r        <= '0;
         res_dout     <= '0;
         res_tag      <= '0;
         res_err      <= 1'b0;
         res_auth_ok  <= 1'b0;
         res_valid    <= 1'b0;
      end else begin
         av_write     <= wr_n;
         av_read      <= rd_n;
         av_address   <= addr_n;
         av_writedata <= wdata_n;
         if (accept) begin
            mode_r      <= job_mode;
            key_r       <= job_key;
            nonce_r     <= job_nonce;
            ad_r        <= job_ad;
            din_r       <= job_din;
            res_dout    <= '0;
            res_tag     <= '0;
            res_err     <= 1'b0;
            res_auth_ok <= 1'b0;
         end
         if (cap_status)
            res_auth_ok <= av_readdata[STATUS_AUTH] && (mode_r == MODE_DEC);
         if (cap_word)
            {res_dout, res_tag} <= {res_dout[95:0], res_tag, av_readdata};
         if (set_err) begin
            res_err     <= 1'b1;
            res_auth_ok <= 1'b0;
         end
         if (set_valid)
            res_valid <= 1'b1;
         else if (state == RESP && res_valid && res_ready)
            res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ascon_job_sequencer.sv
// Directed bench for ascon_job_sequencer against a small ascon_wrapper register model.
module tb_ascon_job_sequencer;
   import ascon_pkg::*;

   localparam int RL   = 1;
   localparam int GAP  = 4;
   localparam int PMAX = 4;

   localparam logic [127:0] KEY_A   = 128'h1234567890ABCDEF1234567890ABCDEF;
   localparam logic [127:0] NONCE_A = 128'hFEDCBA9876543210FEDCBA9876543210;
   localparam logic [127:0] AD_A    = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [127:0] DIN_A   = 128'h01234567_89ABCDEF_00112233_44556677;
   localparam logic [127:0] KEY_B   = 128'hCAFEBABE_00000001_00000002_00000003;
   localparam logic [127:0] KEY_C   = 128'h55555555_66666666_77777777_88888888;
   localparam logic [127:0] DOUT_EXP = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] TAG_EXP  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         job_valid = 1'b0;
   logic         job_ready;
   logic [1:0]   job_mode = 2'd0;
   logic [127:0] job_key = '0, job_nonce = '0, job_ad = '0, job_din = '0;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [127:0] res_dout, res_tag;
   logic         res_auth_ok, res_err;
   logic         av_chipselect, av_write, av_read;
   logic [4:0]   av_address;
   logic [31:0]  av_writedata, av_readdata;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int acc_cyc = 0;

   ascon_job_sequencer #(
      .READ_LATENCY (RL),
      .POLL_GAP     (GAP),
      .POLL_MAX     (PMAX)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_mode      (job_mode),
      .job_key       (job_key),
      .job_nonce     (job_nonce),
      .job_ad        (job_ad),
      .job_din       (job_din),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_dout      (res_dout),
      .res_tag       (res_tag),
      .res_auth_ok   (res_auth_ok),
      .res_err       (res_err),
      .av_chipselect (av_chipselect),
      .av_write      (av_write),
      .av_read       (av_read),
      .av_address    (av_address),
      .av_writedata  (av_writedata),
      .av_readdata   (av_readdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register slave model: logs every access and answers reads RL=1 cycle later.
   int          done_after = 1;
   logic        slave_auth = 1'b0;
   int          status_seen = 0;
   int          status_base = 0;
   logic        rd_pend = 1'b0;
   logic [31:0] rd_data_q = '0;
   logic [4:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];
   logic [4:0]  rd_addr_q[$];
   int          rd_cyc_q[$];
   int          wr_base = 0, rd_base = 0;
   int          both_err = 0, cs_err = 0;

   function automatic logic [31:0] slave_word(input logic [4:0] a);
      case (a)
         REG_DOUT0:       return 32'h00010203;
         REG_DOUT0 + 5'd1: return 32'h04050607;
         REG_DOUT0 + 5'd2: return 32'h08090A0B;
         REG_DOUT0 + 5'd3: return 32'h0C0D0E0F;
         REG_TAG0:        return 32'hA0A1A2A3;
         REG_TAG0 + 5'd1:  return 32'hA4A5A6A7;
         REG_TAG0 + 5'd2:  return 32'hA8A9AAAB;
         REG_TAG0 + 5'd3:  return 32'hACADAEAF;
         default:         return 32'hDEADBEEF;
      endcase
   endfunction

   always @(posedge clk) begin
      rd_pend <= 1'b0;
      if (av_write) begin
         wr_addr_q.push_back(av_address);
         wr_data_q.push_back(av_writedata);
         wr_cyc_q.push_back(cyc);
      end
      if (av_read) begin
         rd_addr_q.push_back(av_address);
         rd_cyc_q.push_back(cyc);
         rd_pend <= 1'b1;
         if (av_address == REG_STATUS) begin
            rd_data_q   <= {30'b0, slave_auth, ((status_seen + 1 - status_base) >= done_after)};
            status_seen <= status_seen + 1;
         end else begin
            rd_data_q <= slave_word(av_address);
         end
      end
   end

   assign av_readdata = rd_pend ? rd_data_q : 32'h0;

   always @(negedge clk) begin
      if (!rst) begin
         if (av_write && av_read) both_err <= both_err + 1;
         if (av_chipselect !== (av_write | av_read)) cs_err <= cs_err + 1;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mark_logs();
      wr_base     = wr_addr_q.size();
      rd_base     = rd_addr_q.size();
      status_base = status_seen;
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic apply_stimulus(input logic [1:0] mode, input logic [127:0] key,
                                 input logic [127:0] nonce, input logic [127:0] ad,
                                 input logic [127:0] din);
      int n;
      n = 0;
      while (job_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_output("job_ready_before_accept", 128'(job_ready), 128'(1));
      job_mode  = mode;
      job_key   = key;
      job_nonce = nonce;
      job_ad    = ad;
      job_din   = din;
      job_valid = 1'b1;
      @(negedge clk);
      acc_cyc   = cyc;
      job_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            lat = cyc - acc_cyc;
            break;
         end
      end
      if (lat < 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL res_valid_wait: observed timeout expected res_valid within 300 cycles");
      end
   endtask

   initial begin
      int lat, bad, nst, nout;
      int st_cyc[$];
      logic [127:0] snap_dout, snap_tag;

      // Reset state
      @(negedge clk);
      check_output("rst_job_ready", 128'(job_ready), 128'(1));
      check_output("rst_res_valid", 128'(res_valid), 128'(0));
      check_output("rst_strobes", 128'({av_write, av_read, av_chipselect}), 128'(0));
      check_output("rst_av_address", 128'(av_address), 128'(0));
      check_output("rst_res_dout", res_dout, 128'(0));
      check_output("rst_res_err", 128'(res_err), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // A: encrypt, done on first poll: write order, data words, latency
      done_after = 1;
      slave_auth = 1'b0;
      mark_logs();
      apply_stimulus(MODE_ENC, KEY_A, NONCE_A, AD_A, DIN_A);
      wait_result(lat);
      check_output("A_latency", 128'(lat), 128'(38));
      check_output("A_res_err", 128'(res_err), 128'(0));
      check_output("A_res_dout", res_dout, DOUT_EXP);
      check_output("A_res_tag", res_tag, TAG_EXP);
      check_output("A_auth_enc", 128'(res_auth_ok), 128'(0));
      check_output("A_write_count", 128'(wr_addr_q.size() - wr_base), 128'(18));
      if (wr_addr_q.size() >= wr_base + 18) begin
         bad = 0;
         for (int i = 0; i < 16; i++)
            if (wr_addr_q[wr_base + i] !== 5'(i + 1)) bad++;
         check_output("A_write_order", 128'(bad), 128'(0));
         check_output("A_ctrl_addrs", 128'({wr_addr_q[wr_base + 16], wr_addr_q[wr_base + 17]}), 128'(0));
         check_output("A_key_word0", 128'(wr_data_q[wr_base]), 128'(32'h12345678));
         check_output("A_nonce_word0", 128'(wr_data_q[wr_base + 4]), 128'(32'hFEDCBA98));
         check_output("A_ad_word1", 128'(wr_data_q[wr_base + 9]), 128'(32'h5A5A5A5A));
         check_output("A_din_word3", 128'(wr_data_q[wr_base + 15]), 128'(32'h44556677));
         check_output("A_ctrl_start", 128'(wr_data_q[wr_base + 16]), 128'(32'h1));
         check_output("A_ctrl_clear", 128'(wr_data_q[wr_base + 17]), 128'(32'h0));
         check_output("A_first_write_lat", 128'(wr_cyc_q[wr_base] - acc_cyc), 128'(1));
      end
      check_output("A_read_count", 128'(rd_addr_q.size() - rd_base), 128'(9));
      if (rd_addr_q.size() >= rd_base + 9) begin
         bad = 0;
         if (rd_addr_q[rd_base] !== REG_STATUS) bad++;
         for (int i = 0; i < 8; i++)
            if (rd_addr_q[rd_base + 1 + i] !== REG_DOUT0 + 5'(i)) bad++;
         check_output("A_read_order", 128'(bad), 128'(0));
      end
      @(negedge clk);

      // B: done after 3 polls, poll spacing
      done_after = 3;
      mark_logs();
      apply_stimulus(MODE_ENC, KEY_B, NONCE_A, AD_A, DIN_A);
      wait_result(lat);
      st_cyc.delete();
      for (int i = rd_base; i < rd_addr_q.size(); i++)
         if (rd_addr_q[i] == REG_STATUS) st_cyc.push_back(rd_cyc_q[i]);
      nst = st_cyc.size();
      check_output("B_status_reads", 128'(nst), 128'(3));
      if (nst == 3) begin
         check_output("B_poll_gap1", 128'(st_cyc[1] - st_cyc[0]), 128'(GAP + RL + 1));
         check_output("B_poll_gap2", 128'(st_cyc[2] - st_cyc[1]), 128'(GAP + RL + 1));
      end
      check_output("B_res_dout", res_dout, DOUT_EXP);
      check_output("B_res_err", 128'(res_err), 128'(0));
      @(negedge clk);

      // C: decrypt with tag match
      done_after = 1;
      slave_auth = 1'b1;
      mark_logs();
      apply_stimulus(MODE_DEC, KEY_A, NONCE_A, AD_A, DIN_A);
      wait_result(lat);
      if (wr_data_q.size() >= wr_base + 18) begin
         check_output("C_ctrl_start", 128'(wr_data_q[wr_base + 16]), 128'(32'h3));
         check_output("C_ctrl_clear", 128'(wr_data_q[wr_base + 17]), 128'(32'h2));
      end
      check_output("C_auth_ok", 128'(res_auth_ok), 128'(1));
      check_output("C_res_tag", res_tag, TAG_EXP);
      slave_auth = 1'b0;
      @(negedge clk);

      // D: done never set -> timeout after PMAX polls
      done_after = 1000;
      mark_logs();
      apply_stimulus(MODE_ENC, KEY_C, NONCE_A, AD_A, DIN_A);
      wait_result(lat);
      nst  = 0;
      nout = 0;
      for (int i = rd_base; i < rd_addr_q.size(); i++) begin
         if (rd_addr_q[i] == REG_STATUS) nst++;
         else nout++;
      end
      check_output("D_status_reads", 128'(nst), 128'(PMAX));
      check_output("D_readout_reads", 128'(nout), 128'(0));
      check_output("D_res_err", 128'(res_err), 128'(1));
      check_output("D_res_dout", res_dout, 128'(0));
      check_output("D_res_tag", res_tag, 128'(0));
      @(negedge clk);

      // E: illegal mode
      done_after = 1;
      mark_logs();
      apply_stimulus(2'd2, KEY_A, NONCE_A, AD_A, DIN_A);
      wait_result(lat);
      check_output("E_latency", 128'(lat), 128'(1));
      check_output("E_res_err", 128'(res_err), 128'(1));
      check_output("E_bus_accesses", 128'((wr_addr_q.size() - wr_base) + (rd_addr_q.size() - rd_base)), 128'(0));
      check_output("E_res_dout", res_dout, 128'(0));
      @(negedge clk);

      // F: backpressure on result, plus a job offered while busy
      res_ready = 1'b0;
      mark_logs();
      apply_stimulus(MODE_ENC, KEY_B, NONCE_A, AD_A, DIN_A);
      job_key   = KEY_C;
      job_valid = 1'b1;
      wait_result(lat);
      snap_dout = res_dout;
      snap_tag  = res_tag;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || job_ready !== 1'b0 || res_err !== 1'b0) bad++;
         if (res_dout !== snap_dout || res_tag !== snap_tag) bad++;
      end
      check_output("F_hold_stable", 128'(bad), 128'(0));
      check_output("F_hold_dout", res_dout, DOUT_EXP);
      check_output("F_busy_writes", 128'(wr_addr_q.size() - wr_base), 128'(18));
      if (wr_data_q.size() > wr_base)
         check_output("F_busy_key", 128'(wr_data_q[wr_base]), 128'(32'hCAFEBABE));
      job_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      check_output("F_release_valid", 128'(res_valid), 128'(0));
      check_output("F_release_ready", 128'(job_ready), 128'(1));
      @(negedge clk);

      // G: reset in the middle of the config writes
      mark_logs();
      apply_stimulus(MODE_ENC, KEY_A, NONCE_A, AD_A, DIN_A);
      repeat (5) @(negedge clk);
      check_output("G_write_before_rst", 128'(av_write), 128'(1));
      rst = 1'b1;
      #1;
      check_output("G_strobes_in_rst", 128'({av_write, av_read, av_chipselect}), 128'(0));
      check_output("G_ready_in_rst", 128'(job_ready), 128'(1));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mark_logs();
      apply_stimulus(MODE_ENC, KEY_B, NONCE_A, AD_A, DIN_A);
      wait_result(lat);
      check_output("G_latency", 128'(lat), 128'(38));
      check_output("G_res_dout", res_dout, DOUT_EXP);
      check_output("G_res_err", 128'(res_err), 128'(0));
      check_output("G_write_count", 128'(wr_addr_q.size() - wr_base), 128'(18));
      @(negedge clk);

      check_output("both_strobes", 128'(both_err), 128'(0));
      check_output("chipselect", 128'(cs_err), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
